// File: rtl/mc_bus_pkg.sv
// Shared definitions for the PE-array multicast bus: transmitter states,
// skid depth and the ID/length widths also used by the receiving routers.
package mc_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mc_tx_state_e;

   localparam int MC_TX_SKID_DEPTH = 2;
   localparam int MC_BUS_ID_W      = 8;
   localparam int MC_BUS_LEN_W     = 8;

endpackage

// File: rtl/mc_tx_skid_fifo.sv
// Two-entry skid FIFO between the 1-cycle SRAM read port and the bus.
// Storage is not reset; only pointers and occupancy are.
module mc_tx_skid_fifo
   import mc_bus_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] slot_q [MC_TX_SKID_DEPTH];
   logic [DATA_WIDTH-1:0] slot_d [MC_TX_SKID_DEPTH];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;

   always_comb begin
      slot_d   = slot_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         slot_d[wr_ptr_q] = push_data;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

   assign head  = slot_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/mc_bus_tx.sv
// Multicast bus transmitter: streams cmd_len SRAM words onto a PE column bus
// tagged with cmd_id. Define MC_BUS_TX_STRIDE_EN to add a cmd_stride input.
module mc_bus_tx
   import mc_bus_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ID_WIDTH   = MC_BUS_ID_W,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = MC_BUS_LEN_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
`ifdef MC_BUS_TX_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   input  logic                  bus_ready,
   output logic                  bus_valid,
   output logic [DATA_WIDTH-1:0] bus_data,
   output logic [ID_WIDTH-1:0]   bus_id,
   output logic                  busy,
   output logic                  done
);

   mc_tx_state_e          state_q, state_d;
   logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
   logic [LEN_WIDTH-1:0]  tx_cnt_q, tx_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic                  inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0] step;
   logic [1:0]            fifo_count;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  pop;
   logic                  rd_en;
   logic [2:0]            occ_after;

`ifdef MC_BUS_TX_STRIDE_EN
   logic [ADDR_WIDTH-1:0] stride_q, stride_d;
   assign step = stride_q;
`else
   assign step = ADDR_WIDTH'(1);
`endif

   assign bus_valid = (fifo_count != 2'd0);
   assign pop       = bus_valid & bus_ready;

   // Occupancy after this cycle's pop lets a read overlap the pop, sustaining one word per cycle.
   assign occ_after = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_en     = (state_q == FETCH) && (rd_cnt_q != '0)
                      && (occ_after < 3'(MC_TX_SKID_DEPTH));

   always_comb begin
      state_d    = state_q;
      rd_cnt_d   = rd_cnt_q;
      tx_cnt_d   = tx_cnt_q;
      addr_d     = addr_q;
      id_d       = id_q;
      inflight_d = rd_en;
`ifdef MC_BUS_TX_STRIDE_EN
      stride_d   = stride_q;
`endif
      if (pop) begin
         tx_cnt_d = tx_cnt_q - LEN_WIDTH'(1);
      end
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               id_d     = cmd_id;
               addr_d   = cmd_base;
               rd_cnt_d = cmd_len;
               tx_cnt_d = cmd_len;
`ifdef MC_BUS_TX_STRIDE_EN
               stride_d = cmd_stride;
`endif
               state_d  = (cmd_len == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (rd_en) begin
               addr_d   = addr_q + step;
               rd_cnt_d = rd_cnt_q - LEN_WIDTH'(1);
               if (rd_cnt_q == LEN_WIDTH'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Leave on the final pop so done follows the last beat directly.
            if ((tx_cnt_q == '0) || ((tx_cnt_q == LEN_WIDTH'(1)) && pop)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_cnt_q   <= '0;
         tx_cnt_q   <= '0;
         addr_q     <= '0;
         id_q       <= '0;
         inflight_q <= 1'b0;
`ifdef MC_BUS_TX_STRIDE_EN
         stride_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         tx_cnt_q   <= tx_cnt_d;
         addr_q     <= addr_d;
         id_q       <= id_d;
         inflight_q <= inflight_d;
`ifdef MC_BUS_TX_STRIDE_EN
         stride_q   <= stride_d;
`endif
      end
   end

   mc_tx_skid_fifo #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (inflight_q),
      .push_data(mem_rd_data),
      .pop      (pop),
      .head     (fifo_head),
      .count    (fifo_count)
   );

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign mem_rd_en   = rd_en;
   assign mem_rd_addr = addr_q;
   assign bus_id      = id_q;
   assign bus_data    = bus_valid ? fifo_head : '0;

endmodule

// File: tb/tb_mc_bus_tx.sv
// Self-checking bench for mc_bus_tx: randomized transfers and backpressure against
// a queue-based reference of the words and addresses each command must produce.
module tb_mc_bus_tx;

   localparam int DW = 16;
   localparam int IW = 8;
   localparam int AW = 8;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [IW-1:0] cmd_id;
   logic [AW-1:0] cmd_base;
   logic [LW-1:0] cmd_len;
`ifdef MC_BUS_TX_STRIDE_EN
   logic [AW-1:0] cmd_stride;
`endif
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic          bus_ready;
   logic          bus_valid;
   logic [DW-1:0] bus_data;
   logic [IW-1:0] bus_id;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   mc_bus_tx #(
      .DATA_WIDTH(DW), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_id     (cmd_id),
      .cmd_base   (cmd_base),
      .cmd_len    (cmd_len),
`ifdef MC_BUS_TX_STRIDE_EN
      .cmd_stride (cmd_stride),
`endif
      .mem_rd_en  (mem_rd_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .bus_ready  (bus_ready),
      .bus_valid  (bus_valid),
      .bus_data   (bus_data),
      .bus_id     (bus_id),
      .busy       (busy),
      .done       (done)
   );

   // SRAM model with one cycle of read latency
   logic [DW-1:0] mem [256];
   initial mem_rd_data = '0;
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // bus_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
   int ready_mode = 0;
   initial begin
      int ph;
      ph = 0;
      bus_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus_ready = 1'b1;
            1:       bus_ready = (ph % 3 == 0);
            default: bus_ready = 1'($urandom_range(0, 1));
         endcase
         ph++;
      end
   end

   // Reference model and monitor, sampled on the falling edge
   logic [DW-1:0] exp_data [$];
   logic [AW-1:0] exp_addr [$];
   logic [IW-1:0] cur_id = '0;
   logic [AW-1:0] mon_a, mon_st;
   logic [DW-1:0] prev_data = '0;
   logic          prev_stall = 1'b0;
   logic          prev_done = 1'b0;
   int cyc = 0, occ = 0, accepts = 0, done_cnt = 0;
   int beats_t = 0, rds_t = 0, acc_cyc = 0, first_vld_cyc = -1, last_beat_cyc = 0, done_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_data.delete();
         exp_addr.delete();
         occ        = 0;
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", bus_valid, 1);
            chk("stall_data", bus_data, prev_data);
         end
         if (bus_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
         if (bus_valid && bus_ready) begin
            occ--;
            beats_t++;
            last_beat_cyc = cyc;
            if (exp_data.size() == 0) chk("beat_extra", 1, 0);
            else chk("beat_data", bus_data, exp_data.pop_front());
            chk("beat_id", bus_id, cur_id);
         end
         if (mem_rd_en) begin
            occ++;
            rds_t++;
            if (exp_addr.size() == 0) chk("rd_extra", 1, 0);
            else chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
            chk("rd_occupancy_le2", occ <= 2, 1);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_all_sent", exp_data.size(), 0);
            chk("done_one_cycle", prev_done, 0);
         end
         if (cmd_valid && cmd_ready) begin
            accepts++;
            acc_cyc       = cyc;
            first_vld_cyc = -1;
            beats_t       = 0;
            rds_t         = 0;
            cur_id        = cmd_id;
            mon_a         = cmd_base;
`ifdef MC_BUS_TX_STRIDE_EN
            mon_st        = cmd_stride;
`else
            mon_st        = AW'(1);
`endif
            exp_data.delete();
            exp_addr.delete();
            for (int i = 0; i < int'(cmd_len); i++) begin
               exp_addr.push_back(mon_a);
               exp_data.push_back(mem[mon_a]);
               mon_a = mon_a + mon_st;
            end
         end
         prev_stall = bus_valid && !bus_ready;
         prev_data  = bus_data;
         prev_done  = done;
      end
   end

   task automatic send(input logic [IW-1:0] id, input logic [AW-1:0] base, input logic [LW-1:0] len);
      @(posedge clk);
      #1;
      cmd_id    = id;
      cmd_base  = base;
      cmd_len   = len;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int n;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_within_budget", done_cnt != d0, 1);
      @(negedge clk);
   endtask

   task automatic run(input logic [IW-1:0] id, input logic [AW-1:0] base, input logic [LW-1:0] len,
                      input int mode);
      int d0, a0;
      ready_mode = mode;
      d0 = done_cnt;
      a0 = accepts;
      send(id, base, len);
      wait_done(d0, 4 * int'(len) + 50);
      chk("accepted_once", accepts - a0, 1);
      chk("beats", beats_t, int'(len));
      chk("reads", rds_t, int'(len));
      chk("cmd_ready_back", cmd_ready, 1);
      chk("busy_back", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, a0, n;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_id    = '0;
      cmd_base  = '0;
      cmd_len   = '0;
`ifdef MC_BUS_TX_STRIDE_EN
      cmd_stride = AW'(1);
`endif
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_rd_addr", mem_rd_addr, 0);
      chk("rst_bus_data", bus_data, 0);
      chk("rst_bus_id", bus_id, 0);
      chk("rst_done", done, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // streaming: bus_valid rises on the 2nd edge after the accept edge, done right after the last beat
      run(8'h05, 8'h10, 8'd4, 0);
      chk("stream_first_valid", first_vld_cyc - acc_cyc, 3);
      chk("stream_contiguous", last_beat_cyc - first_vld_cyc, 3);
      chk("stream_done_after_last", done_cyc - last_beat_cyc, 1);

      // backpressure
      run(8'h06, 8'h20, 8'd6, 1);

      // empty transfer
      run(8'h07, 8'h30, 8'd0, 0);
      chk("empty_no_valid", first_vld_cyc, -1);
      chk("empty_done_latency", (done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2), 1);

      // address wrap
      run(8'h11, 8'hFE, 8'd4, 0);

`ifdef MC_BUS_TX_STRIDE_EN
      cmd_stride = AW'(3);
      run(8'h12, 8'h00, 8'd4, 0);
      cmd_stride = AW'(0);
      run(8'h13, 8'h44, 8'd3, 1);
      cmd_stride = AW'(1);
`endif

      // command offered while busy is ignored
      ready_mode = 1;
      d0 = done_cnt;
      a0 = accepts;
      send(8'h33, 8'h40, 8'd8);
      send(8'h99, 8'h00, 8'd5);
      wait_done(d0, 100);
      chk("busy_cmd_ignored", accepts - a0, 1);
      chk("busy_beats", beats_t, 8);

      // reset in the middle of a transfer
      ready_mode = 0;
      send(8'h21, 8'h80, 8'd8);
      n = 0;
      while (beats_t < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("mid_reset_reached_2", beats_t >= 2, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_reset_valid", bus_valid, 0);
      chk("mid_reset_busy", busy, 0);
      chk("mid_reset_ready", cmd_ready, 1);
      chk("mid_reset_done", done, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run(8'h22, 8'h90, 8'd2, 0);

      // randomized transfers
      for (int t = 0; t < 8; t++) begin
         run(IW'($urandom), AW'($urandom), LW'($urandom_range(0, 20)), 2);
      end
      run(8'hAB, AW'($urandom), 8'd255, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
